// File: rtl/n101_qspi_icb_arbiter_pkg.sv
// Shared constants and helpers for the QSPI ICB round-robin arbiter.
// Widths here are sized for the largest legal requester count (8).
package n101_qspi_arb_pkg;

  localparam int unsigned MAX_N    = 8;
  localparam int unsigned MAX_IDXW = 3;

  // Requester index width: $clog2(n), never below 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo n; returns ptr when none is valid.
  function automatic logic [MAX_IDXW-1:0] rr_pick(input logic [MAX_N-1:0]    valid,
                                                  input logic [MAX_IDXW-1:0] ptr,
                                                  input int unsigned         n);
    logic [MAX_IDXW-1:0] idx;
    logic [MAX_IDXW-1:0] pick;
    logic                found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        if (!found && valid[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
        idx = (idx == MAX_IDXW'(n - 1)) ? '0 : idx + MAX_IDXW'(1);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/n101_qspi_icb_arbiter_if.sv
// ICB command/response bundle with NL lanes; rsp_rdata is a single shared 32-bit bus.
// The requester side uses NL = N, the QSPI wrapper side uses NL = 1.
interface n101_qspi_icb_arbiter_if #(
  parameter int unsigned NL = 1,
  parameter int unsigned AW = 32
);
  logic [NL-1:0]    cmd_valid;
  logic [NL-1:0]    cmd_ready;
  logic [NL*AW-1:0] cmd_addr;
  logic [NL-1:0]    cmd_read;
  logic [NL*32-1:0] cmd_wdata;
  logic [NL-1:0]    rsp_valid;
  logic [NL-1:0]    rsp_ready;
  logic [31:0]      rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/n101_qspi_icb_arbiter_fifo.sv
// Route FIFO: records the granted requester index per outstanding command.
// Head is read combinationally; push when full and pop when empty are ignored.
module n101_qspi_arb_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/n101_qspi_icb_arbiter.sv
// Round-robin ICB arbiter sharing the QSPI wrapper's single slave port among N requesters.
// Commands pass through combinationally; in-order responses are steered by the route FIFO.
module n101_qspi_icb_arbiter
  import n101_qspi_arb_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned OUTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  n101_qspi_icb_arbiter_if.slave  m_icb,
  n101_qspi_icb_arbiter_if.master s_icb,
  output logic                   busy
);

  localparam int unsigned IDXW = idx_width(N);

  logic            lock;
  logic [IDXW-1:0] lock_idx;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] head;
  logic            any_valid;
  logic            cmd_valid;
  logic            cmd_hs;
  logic            rsp_hs;
  logic            fifo_full;
  logic            fifo_empty;

  // A pending (unaccepted) command pins the winner so its payload cannot change.
  always_comb begin
    winner = lock ? lock_idx
                  : IDXW'(rr_pick(MAX_N'(m_icb.cmd_valid), MAX_IDXW'(rr_ptr), N));
  end

  assign any_valid = |m_icb.cmd_valid;
  assign cmd_valid = any_valid & ~fifo_full;
  assign cmd_hs    = cmd_valid & s_icb.cmd_ready[0];

  assign s_icb.cmd_valid = cmd_valid;
  assign s_icb.cmd_addr  = m_icb.cmd_addr[winner*AW +: AW];
  assign s_icb.cmd_read  = m_icb.cmd_read[winner];
  assign s_icb.cmd_wdata = m_icb.cmd_wdata[winner*32 +: 32];

  assign s_icb.rsp_ready = ~fifo_empty & m_icb.rsp_ready[head];
  assign rsp_hs          = s_icb.rsp_valid[0] & s_icb.rsp_ready[0];
  assign m_icb.rsp_rdata = s_icb.rsp_rdata;

  // cmd_ready is also gated by any_valid so no requester sees ready while all are idle.
  always_comb begin
    m_icb.cmd_ready         = '0;
    m_icb.rsp_valid         = '0;
    m_icb.cmd_ready[winner] = cmd_valid & s_icb.cmd_ready[0];
    m_icb.rsp_valid[head]   = s_icb.rsp_valid[0] & ~fifo_empty;
  end

  assign busy = cmd_valid | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else if (cmd_hs) begin
      lock   <= 1'b0;
      rr_ptr <= (winner == IDXW'(N - 1)) ? '0 : winner + IDXW'(1);
    end else if (cmd_valid) begin
      lock     <= 1'b1;
      lock_idx <= winner;
    end
  end

  n101_qspi_arb_fifo #(
    .W     (IDXW),
    .DEPTH (OUTS)
  ) u_route_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_hs),
    .push_data (winner),
    .pop       (rsp_hs),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
